vxe_mem_req_arb: RTL and testbench
==================================

Name: vxe_mem_req_arb

Overview:
- Memory request arbiter between the three transaction clients: CU (client id 0), VPU0 (1), VPU1 (2).
- Grants one request per cycle into a single registered output slot, round-robin.
- Tags each granted request with a 6-bit txnid = {client_id[1:0], thread_id[2:0], argument}.
- Tracks outstanding transactions per client by decoding returned response txnids, and throttles any client that reaches its limit.

Parameters:
- ADDR_W, 40, request address width.
- MAX_OUTST, 8, max in-flight transactions per client (1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_cu_req  in  1  CU request valid.
- i_cu_addr  in  ADDR_W  CU address.
- i_cu_thread  in  3  CU thread id (normally 0).
- i_cu_arg  in  1  CU argument type (0=Rs, 1=Rt).
- o_cu_rdy  out  1  CU request accepted this cycle.
- i_vpu0_req / i_vpu0_addr / i_vpu0_thread / i_vpu0_arg / o_vpu0_rdy: same as the five CU ports, for VPU0.
- i_vpu1_req / i_vpu1_addr / i_vpu1_thread / i_vpu1_arg / o_vpu1_rdy: same as the five CU ports, for VPU1.
- o_m_req  out  1  memory request valid.
- o_m_addr  out  ADDR_W  memory request address.
- o_m_txnid  out  6  encoded txnid.
- i_m_rdy  in  1  memory accepts request.
- i_rs_vld  in  1  response returned.
- i_rs_txnid  in  6  txnid of returned response.
- o_err  out  1  one-cycle pulse on protocol error.
- o_idle  out  1  no outstanding transactions and no pending output.

Behaviour:
- Reset values: o_m_req=0, o_m_addr=0, o_m_txnid=0, o_err=0, all outstanding counters=0, RR pointer=CU. o_idle=1 while in reset.
- Output slot free when !o_m_req || i_m_rdy.
- Eligible client: req=1 and cnt<MAX_OUTST.
  - cnt is the registered value; a same-cycle response decrement is not credited.
- Grant only when the slot is free and at least one client is eligible.
  - Exactly one o_*_rdy is high, combinationally, in the grant cycle.
  - At most one o_*_rdy is ever high.
- Round-robin order starts at the RR pointer; after a grant to client k the pointer becomes (k+1) mod 3. Pointer unchanged when there is no grant.
- On grant, registered on the next edge:
  - o_m_req=1.
  - o_m_addr = granted addr.
  - o_m_txnid = {client_id, thread, arg}.
  - Latency is 1 cycle from the client handshake to o_m_req.
- Slot free and no grant: o_m_req=0; addr and txnid hold their last values.
- o_m_req=1 && !i_m_rdy: o_m_req, o_m_addr and o_m_txnid stay stable.
- Back-to-back: a new grant in the same cycle as i_m_rdy gives full throughput, one request per cycle.
- Outstanding counters:
  - Width clog2(MAX_OUTST+1).
  - +1 on grant to that client.
  - −1 on i_rs_vld whose txnid[5:4] selects that client.
  - Simultaneous increment and decrement on the same client: unchanged.
- Errors (o_err pulses 1 cycle, registered):
  - Response with txnid[5:4]=3: no counter change.
  - Response to a client whose counter is 0: counter stays 0.
- o_idle = !o_m_req && all counters zero (combinational from registers).
- Reset asserted mid-operation: everything returns to reset values immediately (async).
  - A pending o_m_req is dropped.
  - In-flight responses arriving after reset raise o_err (counters are 0).
- Client inputs are sampled only in the grant cycle. Clients hold req, addr, thread and arg stable until their rdy is seen.

Optional Feature:
- Macro VXE_MEM_ARB_CU_PRIO_EN.
- Defined:
  - CU has strict priority: an eligible CU always wins.
  - VPU0 and VPU1 round-robin between themselves, using a 1-bit pointer that toggles only on a VPU grant.
  - A CU grant leaves the VPU pointer unchanged.
- Undefined: plain 3-way round-robin as above.

Test Plan:
- All three clients request continuously, i_m_rdy=1, responses immediate → grant order CU,VPU0,VPU1,CU,… one per cycle; txnids for VPU1 thread 5 arg 1 = 6'b101011.
- VPU0 alone, no responses, MAX_OUTST=8 → exactly 8 grants, then o_vpu0_rdy stays 0. One response with txnid 6'b01xxxx → exactly one more grant.
- i_m_rdy=0 for 5 cycles with o_m_req=1 → o_m_addr/o_m_txnid unchanged, no o_*_rdy asserted. i_m_rdy=1 → new grant in that same cycle.
- i_rs_vld with txnid 6'b110000, then a response to CU with its counter at 0 → o_err pulses once each, counters unchanged, o_idle stays 1.
- Grant and response to the same client in one cycle with counter=3 → counter stays 3. Assert rst mid-burst → o_m_req=0 immediately, o_idle=1 after release, pointer at CU.
- With VXE_MEM_ARB_CU_PRIO_EN, CU and both VPUs request continuously → CU granted every cycle until CU reaches MAX_OUTST, then VPU0,VPU1 alternate.

Source files
------------

// File: rtl/vxe_mem_req_arb_if.sv
// Bundle of client, memory and response signals for vxe_mem_req_arb.
// The slave modport is the arbiter's view. The master modport is the
// environment that drives the clients, the memory and the response path.
interface vxe_mem_req_arb_if #(
    parameter int ADDR_W = 40
);
    // CU client (id 0)
    logic              i_cu_req;
    logic [ADDR_W-1:0] i_cu_addr;
    logic [2:0]        i_cu_thread;
    logic              i_cu_arg;
    logic              o_cu_rdy;
    // VPU0 client (id 1)
    logic              i_vpu0_req;
    logic [ADDR_W-1:0] i_vpu0_addr;
    logic [2:0]        i_vpu0_thread;
    logic              i_vpu0_arg;
    logic              o_vpu0_rdy;
    // VPU1 client (id 2)
    logic              i_vpu1_req;
    logic [ADDR_W-1:0] i_vpu1_addr;
    logic [2:0]        i_vpu1_thread;
    logic              i_vpu1_arg;
    logic              o_vpu1_rdy;
    // memory request slot
    logic              o_m_req;
    logic [ADDR_W-1:0] o_m_addr;
    logic [5:0]        o_m_txnid;
    logic              i_m_rdy;
    // response return and status
    logic              i_rs_vld;
    logic [5:0]        i_rs_txnid;
    logic              o_err;
    logic              o_idle;

    modport slave (
        input  i_cu_req, i_cu_addr, i_cu_thread, i_cu_arg,
        input  i_vpu0_req, i_vpu0_addr, i_vpu0_thread, i_vpu0_arg,
        input  i_vpu1_req, i_vpu1_addr, i_vpu1_thread, i_vpu1_arg,
        input  i_m_rdy, i_rs_vld, i_rs_txnid,
        output o_cu_rdy, o_vpu0_rdy, o_vpu1_rdy,
        output o_m_req, o_m_addr, o_m_txnid, o_err, o_idle
    );

    modport master (
        output i_cu_req, i_cu_addr, i_cu_thread, i_cu_arg,
        output i_vpu0_req, i_vpu0_addr, i_vpu0_thread, i_vpu0_arg,
        output i_vpu1_req, i_vpu1_addr, i_vpu1_thread, i_vpu1_arg,
        output i_m_rdy, i_rs_vld, i_rs_txnid,
        input  o_cu_rdy, o_vpu0_rdy, o_vpu1_rdy,
        input  o_m_req, o_m_addr, o_m_txnid, o_err, o_idle
    );
endinterface

// File: rtl/vxe_mem_req_arb.sv
// Memory request arbiter for the CU (0), VPU0 (1) and VPU1 (2) clients.
// Grants one request per cycle into a registered output slot, tags it with
// txnid = {client, thread, arg} and counts outstanding transactions per
// client from returned txnids, throttling a client at MAX_OUTST.
// Build option: define VXE_MEM_ARB_CU_PRIO_EN to give the CU strict priority
// with VPU0/VPU1 round-robin between themselves; otherwise plain 3-way RR.
module vxe_mem_req_arb #(
    parameter int ADDR_W    = 40,
    parameter int MAX_OUTST = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    vxe_mem_req_arb_if.slave       bus
);
    localparam int NCLI  = 3;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    // client inputs gathered into index-addressable form
    logic [NCLI-1:0]   req_v;
    logic [ADDR_W-1:0] addr_v   [NCLI];
    logic [2:0]        thread_v [NCLI];
    logic [NCLI-1:0]   arg_v;

    assign req_v       = {bus.i_vpu1_req, bus.i_vpu0_req, bus.i_cu_req};
    assign arg_v       = {bus.i_vpu1_arg, bus.i_vpu0_arg, bus.i_cu_arg};
    assign addr_v[0]   = bus.i_cu_addr;
    assign addr_v[1]   = bus.i_vpu0_addr;
    assign addr_v[2]   = bus.i_vpu1_addr;
    assign thread_v[0] = bus.i_cu_thread;
    assign thread_v[1] = bus.i_vpu0_thread;
    assign thread_v[2] = bus.i_vpu1_thread;

    logic              m_req_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [5:0]        m_txnid_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q [NCLI];
    logic [CNT_W-1:0]  cnt_d [NCLI];

    logic              slot_free;
    logic [NCLI-1:0]   elig;
    logic [NCLI-1:0]   inc;
    logic [NCLI-1:0]   dec;
    logic [NCLI-1:0]   zero_hit;
    logic [NCLI-1:0]   cnt_nz;
    logic              gnt_vld;
    logic [1:0]        gnt_idx;
    logic [1:0]        rs_cli;
    logic              err_d;
    logic [3:0]        unused_rs_low;

    assign slot_free     = !m_req_q || bus.i_m_rdy;
    assign rs_cli        = bus.i_rs_txnid[5:4];
    // thread/arg bits of a response do not affect accounting
    assign unused_rs_low = bus.i_rs_txnid[3:0];

    // per-client eligibility and outstanding accounting
    for (genvar gi = 0; gi < NCLI; gi++) begin : g_cli
        assign elig[gi]     = req_v[gi] && (cnt_q[gi] < CNT_W'(MAX_OUTST));
        assign inc[gi]      = gnt_vld && (gnt_idx == 2'(gi));
        assign dec[gi]      = bus.i_rs_vld && (rs_cli == 2'(gi)) && (cnt_q[gi] != '0);
        assign zero_hit[gi] = bus.i_rs_vld && (rs_cli == 2'(gi)) && (cnt_q[gi] == '0);
        assign cnt_nz[gi]   = (cnt_q[gi] != '0);
        assign cnt_d[gi]    = (inc[gi] && !dec[gi]) ? cnt_q[gi] + CNT_W'(1) :
                              (dec[gi] && !inc[gi]) ? cnt_q[gi] - CNT_W'(1) : cnt_q[gi];

        // outstanding counter per client
        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q[gi] <= '0;
            else     cnt_q[gi] <= cnt_d[gi];
        end
    end

    // response to the unused client id or to a client with nothing in flight
    assign err_d = bus.i_rs_vld && ((rs_cli == 2'd3) || (|zero_hit));

`ifdef VXE_MEM_ARB_CU_PRIO_EN
    logic       vptr_q;
    logic [1:0] vpu_first;
    logic [1:0] vpu_second;

    assign vpu_first  = vptr_q ? 2'd2 : 2'd1;
    assign vpu_second = vptr_q ? 2'd1 : 2'd2;

    // CU wins whenever eligible, VPUs alternate between themselves
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        if (slot_free) begin
            if (elig[0]) begin
                gnt_vld = 1'b1;
                gnt_idx = 2'd0;
            end else if (elig[vpu_first]) begin
                gnt_vld = 1'b1;
                gnt_idx = vpu_first;
            end else if (elig[vpu_second]) begin
                gnt_vld = 1'b1;
                gnt_idx = vpu_second;
            end
        end
    end

    // VPU pointer flips only on a VPU grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            vptr_q <= 1'b0;
        else if (gnt_vld && gnt_idx != 2'd0) vptr_q <= ~vptr_q;
    end
`else
    logic [1:0] ptr_q;
    logic [2:0] rr_sum;
    logic [1:0] rr_cand;

    // first eligible client scanning from the pointer, wrapping modulo 3
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        rr_sum  = 3'd0;
        rr_cand = 2'd0;
        for (int i = 0; i < NCLI; i++) begin
            rr_sum  = {1'b0, ptr_q} + 3'(i);
            rr_cand = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
            if (slot_free && !gnt_vld && elig[rr_cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_cand;
            end
        end
    end

    // pointer moves past the granted client
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ptr_q <= 2'd0;
        else if (gnt_vld) ptr_q <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end
`endif

    // output slot: load on grant, drop when drained, hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req_q   <= 1'b0;
            m_addr_q  <= '0;
            m_txnid_q <= '0;
        end else if (slot_free) begin
            m_req_q <= gnt_vld;
            if (gnt_vld) begin
                m_addr_q  <= addr_v[gnt_idx];
                m_txnid_q <= {gnt_idx, thread_v[gnt_idx], arg_v[gnt_idx]};
            end
        end
    end

    // single-cycle protocol error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.o_cu_rdy   = inc[0];
    assign bus.o_vpu0_rdy = inc[1];
    assign bus.o_vpu1_rdy = inc[2];
    assign bus.o_m_req    = m_req_q;
    assign bus.o_m_addr   = m_addr_q;
    assign bus.o_m_txnid  = m_txnid_q;
    assign bus.o_err      = err_q;
    assign bus.o_idle     = !m_req_q && !(|cnt_nz);
endmodule

// File: tb/tb_vxe_mem_req_arb.sv
// Self-checking bench for vxe_mem_req_arb: a transaction-level model
// (per-client in-flight counts, a round-robin pointer, one output slot) is
// compared against the DUT every cycle, plus directed literal checks.
module tb_vxe_mem_req_arb;
    localparam int ADDR_W = 40;
    localparam int MO     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vxe_mem_req_arb_if #(.ADDR_W(ADDR_W)) bus_if ();
    vxe_mem_req_arb #(.ADDR_W(ADDR_W), .MAX_OUTST(MO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    // client stimulus state
    bit                pend   [3];
    logic [ADDR_W-1:0] c_addr [3];
    logic [2:0]        c_thr  [3];
    bit                c_arg  [3];
    int                req_pct[3];
    bit                fix_ids;
    int                mrdy_pct;
    int                rs_mode;   // 0 none, 1 random, 2 oldest each cycle, 3 manual
    bit                man_vld;
    logic [5:0]        man_txnid;

    // reference model
    int                m_cnt [3];
    int                m_ptr;
    int                m_vptr;
    bit                exp_req;
    logic [ADDR_W-1:0] exp_addr;
    logic [5:0]        exp_txnid;
    bit                exp_err;
    logic [5:0]        inflight[$];

    // observations for directed checks
    int                gcount[3];
    int                gorder[$];
    int                err_seen;
    bit                idle_dropped;
    logic [5:0]        vpu1_txnid_seen;
    int                cyc = 0;

`ifdef VXE_MEM_ARB_CU_PRIO_EN
    int exp_order[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 2};
    int order_rs_mode = 0;
`else
    int exp_order[12] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
    int order_rs_mode = 2;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            pend[i]  = 0;
        end
        m_ptr = 0; m_vptr = 0;
        exp_req = 0; exp_addr = '0; exp_txnid = '0; exp_err = 0;
        inflight.delete();
    endtask

    task automatic drive_idle();
        bus_if.i_cu_req = 0; bus_if.i_vpu0_req = 0; bus_if.i_vpu1_req = 0;
        bus_if.i_rs_vld = 0; bus_if.i_rs_txnid = '0; bus_if.i_m_rdy = 0;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 3; i++) gcount[i] = 0;
        gorder.delete();
        err_seen = 0;
        idle_dropped = 0;
    endtask

    // one cycle: drive at negedge, compare 1 time unit later, advance the model
    task automatic step();
        int   g;
        int   c;
        int   idx;
        int   old[3];
        bit   slot_free;
        bit   elig[3];
        bit   err_n;
        bit   rs_vld;
        logic [5:0] rs_txnid;
        bit   m_rdy;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!pend[i] && $urandom_range(99) < req_pct[i]) begin
                pend[i]   = 1;
                c_addr[i] = ADDR_W'({$urandom(), $urandom()});
                if (fix_ids) begin
                    c_thr[i] = (i == 0) ? 3'd0 : (i == 1) ? 3'd3 : 3'd5;
                    c_arg[i] = (i == 2);
                end else begin
                    c_thr[i] = 3'($urandom_range(7));
                    c_arg[i] = 1'($urandom_range(1));
                end
            end
        end
        m_rdy    = ($urandom_range(99) < mrdy_pct);
        rs_vld   = 0;
        rs_txnid = '0;
        case (rs_mode)
            1: begin
                if (inflight.size() > 0 && $urandom_range(99) < 40) begin
                    idx      = $urandom_range(inflight.size() - 1);
                    rs_vld   = 1;
                    rs_txnid = inflight[idx];
                    inflight.delete(idx);
                end else if ($urandom_range(99) < 4) begin
                    c = $urandom_range(3);
                    if (c == 3 || m_cnt[c] == 0) begin
                        rs_vld   = 1;
                        rs_txnid = {2'(c), 4'($urandom())};
                    end
                end
            end
            2: if (inflight.size() > 0) begin
                rs_vld   = 1;
                rs_txnid = inflight.pop_front();
            end
            3: begin
                rs_vld   = man_vld;
                rs_txnid = man_txnid;
                if (rs_vld) begin
                    idx = -1;
                    foreach (inflight[j]) if (idx < 0 && inflight[j][5:4] == rs_txnid[5:4]) idx = j;
                    if (idx >= 0) inflight.delete(idx);
                end
            end
            default: ;
        endcase

        bus_if.i_cu_req = pend[0];   bus_if.i_cu_addr = c_addr[0];
        bus_if.i_cu_thread = c_thr[0]; bus_if.i_cu_arg = c_arg[0];
        bus_if.i_vpu0_req = pend[1]; bus_if.i_vpu0_addr = c_addr[1];
        bus_if.i_vpu0_thread = c_thr[1]; bus_if.i_vpu0_arg = c_arg[1];
        bus_if.i_vpu1_req = pend[2]; bus_if.i_vpu1_addr = c_addr[2];
        bus_if.i_vpu1_thread = c_thr[2]; bus_if.i_vpu1_arg = c_arg[2];
        bus_if.i_m_rdy = m_rdy;
        bus_if.i_rs_vld = rs_vld;
        bus_if.i_rs_txnid = rs_txnid;
        #1;

        // expected grant from the model
        slot_free = !exp_req || m_rdy;
        for (int i = 0; i < 3; i++) elig[i] = pend[i] && (m_cnt[i] < MO);
        g = -1;
        if (slot_free) begin
`ifdef VXE_MEM_ARB_CU_PRIO_EN
            if (elig[0]) g = 0;
            else if (elig[1 + m_vptr]) g = 1 + m_vptr;
            else if (elig[2 - m_vptr]) g = 2 - m_vptr;
`else
            for (int o = 0; o < 3; o++)
                if (g < 0 && elig[(m_ptr + o) % 3]) g = (m_ptr + o) % 3;
`endif
        end

        chk("cu_rdy",   64'(bus_if.o_cu_rdy),   64'(g == 0));
        chk("vpu0_rdy", 64'(bus_if.o_vpu0_rdy), 64'(g == 1));
        chk("vpu1_rdy", 64'(bus_if.o_vpu1_rdy), 64'(g == 2));
        chk("m_req",    64'(bus_if.o_m_req),    64'(exp_req));
        chk("m_addr",   64'(bus_if.o_m_addr),   64'(exp_addr));
        chk("m_txnid",  64'(bus_if.o_m_txnid),  64'(exp_txnid));
        chk("err",      64'(bus_if.o_err),      64'(exp_err));
        chk("idle",     64'(bus_if.o_idle),
            64'(!exp_req && m_cnt[0] == 0 && m_cnt[1] == 0 && m_cnt[2] == 0));

        // observations for directed checks
        for (int i = 0; i < 3; i++) begin
            if ((i == 0 && bus_if.o_cu_rdy) || (i == 1 && bus_if.o_vpu0_rdy) ||
                (i == 2 && bus_if.o_vpu1_rdy)) begin
                gcount[i]++;
                gorder.push_back(i);
                $display("GNT cycle=%0d client=%0d addr=%h thread=%0d arg=%0d",
                         cyc, i, c_addr[i], c_thr[i], c_arg[i]);
            end
        end
        if (bus_if.o_err) err_seen++;
        if (!bus_if.o_idle) idle_dropped = 1;
        if (bus_if.o_m_req && bus_if.o_m_txnid[5:4] == 2'd2) vpu1_txnid_seen = bus_if.o_m_txnid;

        // model update for the coming edge
        for (int i = 0; i < 3; i++) old[i] = m_cnt[i];
        c = int'(rs_txnid[5:4]);
        err_n = 0;
        if (rs_vld) begin
            if (c == 3) err_n = 1;
            else if (old[c] == 0) err_n = 1;
            else m_cnt[c]--;
        end
        exp_err = err_n;
        if (slot_free) exp_req = (g >= 0);
        if (g >= 0) begin
            m_cnt[g]++;
            exp_addr  = c_addr[g];
            exp_txnid = {2'(g), c_thr[g], c_arg[g]};
            inflight.push_back(exp_txnid);
            m_ptr = (g + 1) % 3;
            if (g > 0) m_vptr ^= 1;
            pend[g] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        drive_idle();
        model_reset();
        @(negedge clk);
        rst = 0;
        clear_obs();
    endtask

    initial begin
        drive_idle();
        bus_if.i_cu_addr = '0; bus_if.i_vpu0_addr = '0; bus_if.i_vpu1_addr = '0;
        bus_if.i_cu_thread = '0; bus_if.i_vpu0_thread = '0; bus_if.i_vpu1_thread = '0;
        bus_if.i_cu_arg = 0; bus_if.i_vpu0_arg = 0; bus_if.i_vpu1_arg = 0;
        fix_ids = 0; mrdy_pct = 100; rs_mode = 0; man_vld = 0; man_txnid = '0;
        vpu1_txnid_seen = '0;
        for (int i = 0; i < 3; i++) begin
            req_pct[i] = 0; c_addr[i] = '0; c_thr[i] = '0; c_arg[i] = 0;
        end
        model_reset();
        clear_obs();

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_req", 64'(bus_if.o_m_req), 64'd0);
        chk("rst_m_addr", 64'(bus_if.o_m_addr), 64'd0);
        chk("rst_m_txnid", 64'(bus_if.o_m_txnid), 64'd0);
        chk("rst_err", 64'(bus_if.o_err), 64'd0);
        chk("rst_idle", 64'(bus_if.o_idle), 64'd1);
        @(negedge clk);
        rst = 0;

        // all three requesting continuously: grant order and VPU1 txnid
        fix_ids = 1; mrdy_pct = 100; rs_mode = order_rs_mode;
        for (int i = 0; i < 3; i++) req_pct[i] = 100;
        repeat (14) step();
        for (int i = 0; i < 12; i++)
            chk($sformatf("order_%0d", i), 64'((gorder.size() > i) ? gorder[i] : -1), 64'(exp_order[i]));
        chk("vpu1_txnid", 64'(vpu1_txnid_seen), 64'(6'b101011));

        // VPU0 alone without responses is throttled at MAX_OUTST
        do_reset();
        fix_ids = 0; rs_mode = 0; req_pct = '{0, 100, 0};
        repeat (14) step();
        chk("vpu0_limit", 64'(gcount[1]), 64'd8);
        rs_mode = 3; man_vld = 1; man_txnid = inflight[0];
        step();
        man_vld = 0;
        repeat (5) step();
        chk("vpu0_one_more", 64'(gcount[1]), 64'd9);

        // memory stall: no grants while held, grant on the release cycle
        do_reset();
        rs_mode = 0; req_pct = '{100, 100, 100}; mrdy_pct = 100;
        repeat (2) step();
        clear_obs();
        mrdy_pct = 0;
        repeat (5) step();
        chk("stall_no_rdy", 64'(gcount[0] + gcount[1] + gcount[2]), 64'd0);
        mrdy_pct = 100;
        step();
        chk("stall_release_gnt", 64'(gcount[0] + gcount[1] + gcount[2]), 64'd1);

        // protocol errors: unused client id, then CU with nothing in flight
        do_reset();
        req_pct = '{0, 0, 0}; rs_mode = 3;
        man_vld = 1; man_txnid = 6'b110000; step();
        man_vld = 0; step();
        man_vld = 1; man_txnid = 6'b000000; step();
        man_vld = 0; repeat (2) step();
        chk("err_pulses", 64'(err_seen), 64'd2);
        chk("err_idle_kept", 64'(idle_dropped), 64'd0);

        // grant and response on the same client in one cycle at count 3
        do_reset();
        rs_mode = 0; req_pct = '{0, 100, 0};
        repeat (3) step();
        rs_mode = 3; man_vld = 1; man_txnid = inflight[0];
        step();
        man_vld = 0;
        repeat (10) step();
        chk("same_cycle_inc_dec", 64'(gcount[1]), 64'd9);

        // asynchronous reset in the middle of a burst
        do_reset();
        fix_ids = 0; rs_mode = 1; req_pct = '{100, 100, 100}; mrdy_pct = 100;
        repeat (6) step();
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("async_rst_m_req", 64'(bus_if.o_m_req), 64'd0);
        chk("async_rst_idle", 64'(bus_if.o_idle), 64'd1);
        drive_idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        clear_obs();
        rs_mode = 0;
        step();
        chk("post_rst_ptr_cu", 64'((gorder.size() > 0) ? gorder[0] : -1), 64'd0);

        // randomized traffic with stalls, responses and stray responses
        do_reset();
        fix_ids = 0; rs_mode = 1;
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 3; i++) req_pct[i] = 20 + $urandom_range(80);
            mrdy_pct = 40 + $urandom_range(60);
            repeat (250) step();
        end

        // drain everything: arbiter must return to idle
        req_pct = '{0, 0, 0}; mrdy_pct = 100; rs_mode = 2;
        repeat (40) step();
        chk("drain_idle", 64'(bus_if.o_idle), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
